// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// the constants that tie byte lanes and word addressing together.
package dm_responder_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of byte lanes in a data word.
    localparam int unsigned BE_W       = 4;
    // Data word width in bits.
    localparam int unsigned WORD_W     = 8 * BE_W;
    // Shift turning a byte offset into a word index.
    localparam int unsigned WORD_SHIFT = 2;

endpackage

// File: rtl/dm_responder_ram.sv
// Single-port synchronous word array with a per-byte write mask and a
// registered read port. The read register only updates on an enabled access,
// so its output holds the last access result for as long as needed.
module dm_responder_ram
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Byte-masked write and registered read on every enabled access.
    // NOTE: the array and its read register have no reset; clearing a memory
    // would need a port per word, and contents are undefined at power-up anyway.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < int'(BE_W); i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the MEM-stage load/store port. Accepts one
// request at a time, burns WAIT_CYCLES wait states, performs a byte-masked
// access and then presents the result until the requester takes it.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [BE_W-1:0]   be_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rdata_sel_q;

    logic [31:0]       offset;
    logic [31:0]       word_idx;
    logic              acc_err;
    logic              access;
    logic [WORD_W-1:0] ram_rdata;

    // Decode the latched address and flag the cycle whose edge performs the access.
    // NOTE: every signal gets a value on every path through always_comb, otherwise
    // synthesis infers a latch to remember the old value.
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        word_idx = offset >> WORD_SHIFT;
        // The addr < BASE_ADDR term stops a wrapped subtraction from
        // landing on a valid index.
        acc_err  = (addr_q[WORD_SHIFT-1:0] != '0)
                 | (addr_q < BASE_ADDR)
                 | (word_idx >= DEPTH_WORDS);
        access   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    end

    dm_responder_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (access & ~acc_err),
        .we_i    (we_q),
        .be_i    (be_q),
        .addr_i  (word_idx[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Request/response FSM with wait-state counter and registered handshake outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_sel_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        be_q        <= req_be;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        // The access edge follows WAIT_CYCLES full wait cycles,
                        // so WAIT_CYCLES = 0 still gives one cycle of latency.
                        cnt_q       <= 4'(WAIT_CYCLES);
                        req_ready_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        rdata_sel_q <= ~we_q & ~acc_err;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rdata_sel_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    // RAM read register is stable through RESP; stores and errors read as zero.
    assign rsp_rdata = rdata_sel_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a WAIT_CYCLES = 2 instance for the
// main scenarios and a WAIT_CYCLES = 0 instance with a non-zero base address
// for back-to-back traffic. Expected values come from a word-array model.
module tb_dm_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          WAITC   = 2;
    localparam int unsigned F_DEPTH = 64;
    localparam logic [31:0] F_BASE  = 32'h0000_0100;
    localparam logic [31:0] INTRUDER_ADDR = 32'h0000_0008;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [3:0]  req_be;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        f_req_valid, f_req_ready, f_req_we, f_rsp_valid, f_rsp_ready, f_rsp_err;
    logic [3:0]  f_req_be;
    logic [31:0] f_req_addr, f_req_wdata, f_rsp_rdata;

    int checks = 0;
    int passed = 0;

    logic [31:0] mem2 [DEPTH];
    logic [31:0] mem0 [F_DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dm_responder #(.DEPTH_WORDS(F_DEPTH), .BASE_ADDR(F_BASE), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_we(f_req_we), .req_be(f_req_be),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_rdata(f_rsp_rdata), .rsp_err(f_rsp_err)
    );

    // Reference model: word-array semantics straight from the access rules.
    function automatic void model_access(input bit fast, input txn_t t,
                                         output logic [31:0] rd, output logic er);
        int unsigned depth = fast ? F_DEPTH : DEPTH;
        logic [31:0] base  = fast ? F_BASE : BASE;
        int unsigned idx;
        rd = '0;
        er = (t.addr % 4 != 0) || (t.addr < base) || ((t.addr - base) / 4 >= depth);
        if (!er) begin
            idx = (t.addr - base) / 4;
            if (t.we) begin
                for (int i = 0; i < 4; i++) begin
                    if (t.be[i]) begin
                        if (fast) mem0[idx][8*i +: 8] = t.wdata[8*i +: 8];
                        else      mem2[idx][8*i +: 8] = t.wdata[8*i +: 8];
                    end
                end
            end else begin
                rd = fast ? mem0[idx] : mem2[idx];
            end
        end
    endfunction

    // One transaction on the WAIT_CYCLES = 2 instance. During 'hold' cycles of
    // backpressure an intruding store is offered and must be ignored.
    task automatic do_txn(input txn_t t, input int hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output bit to, output bit stable, output bit after_ok);
        to = 0; stable = 1; after_ok = 0; lat = 0; rd = '0; er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = t.we; req_be = t.be; req_addr = t.addr; req_wdata = t.wdata;
        for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
        if (!req_ready) begin
            to = 1; req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_be = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            to = 1;
            return;
        end
        rd = rsp_rdata; er = rsp_err;
        if (req_ready !== 1'b0) stable = 0;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = INTRUDER_ADDR; req_wdata = $urandom;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0) stable = 0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        after_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset.req_ready: got %b expected 1", req_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset.rsp_valid: got %b expected 0", rsp_valid); else passed++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset.rsp_rdata: got %h expected 0", rsp_rdata); else passed++;
        checks++; if (rsp_err !== 1'b0) $display("FAIL reset.rsp_err: got %b expected 0", rsp_err); else passed++;
        checks++; if (f_req_ready !== 1'b1) $display("FAIL reset.f_req_ready: got %b expected 1", f_req_ready); else passed++;
        checks++; if (f_rsp_valid !== 1'b0) $display("FAIL reset.f_rsp_valid: got %b expected 0", f_rsp_valid); else passed++;
        checks++; if (f_rsp_rdata !== 32'h0) $display("FAIL reset.f_rsp_rdata: got %h expected 0", f_rsp_rdata); else passed++;
        checks++; if (f_rsp_err !== 1'b0) $display("FAIL reset.f_rsp_err: got %b expected 0", f_rsp_err); else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Full-word store, load, byte-lane merge and load again.
    task automatic test_store_load();
        txn_t ops[4];
        logic [31:0] lit[4];
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        bit to, st, ok;
        ops[0] = '{1'b1, 4'b1111, 32'h10, 32'hDEADBEEF}; lit[0] = 32'h0;
        ops[1] = '{1'b0, 4'b0000, 32'h10, 32'h0};        lit[1] = 32'hDEADBEEF;
        ops[2] = '{1'b1, 4'b0010, 32'h10, 32'h0000AA00}; lit[2] = 32'h0;
        ops[3] = '{1'b0, 4'b1111, 32'h10, 32'hFFFFFFFF}; lit[3] = 32'hDEADAAEF;
        for (int i = 0; i < 4; i++) begin
            do_txn(ops[i], 0, rd, er, lat, to, st, ok);
            model_access(1'b0, ops[i], erd, eer);
            checks++;
            if (to || rd !== erd || er !== eer || lat != WAITC + 1 || !ok)
                $display("FAIL store_load.op%0d: rdata=%h err=%b lat=%0d to=%b rel=%b, expected rdata=%h err=%b lat=%0d",
                         i, rd, er, lat, to, ok, erd, eer, WAITC + 1);
            else passed++;
            checks++;
            if (rd !== lit[i]) $display("FAIL store_load.lit%0d: rdata=%h expected %h", i, rd, lit[i]);
            else passed++;
        end
    endtask

    // Misaligned, out-of-range, zero-mask and last-word accesses.
    task automatic test_errors();
        txn_t ops[9];
        logic [31:0] lit_rd[9];
        logic lit_er[9];
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        bit to, st, ok;
        ops[0] = '{1'b1, 4'b1111, 32'h12, 32'hFFFFFFFF};       lit_rd[0] = 32'h0;        lit_er[0] = 1'b1;
        ops[1] = '{1'b0, 4'b1111, 32'h10, 32'h0};              lit_rd[1] = 32'hDEADAAEF; lit_er[1] = 1'b0;
        ops[2] = '{1'b0, 4'b1111, 32'h12, 32'h0};              lit_rd[2] = 32'h0;        lit_er[2] = 1'b1;
        ops[3] = '{1'b0, 4'b1111, 32'h1000, 32'h0};            lit_rd[3] = 32'h0;        lit_er[3] = 1'b1;
        ops[4] = '{1'b1, 4'b0000, 32'h10, 32'h12345678};       lit_rd[4] = 32'h0;        lit_er[4] = 1'b0;
        ops[5] = '{1'b0, 4'b0000, 32'h10, 32'h0};              lit_rd[5] = 32'hDEADAAEF; lit_er[5] = 1'b0;
        ops[6] = '{1'b1, 4'b1111, 32'hFFC, 32'hCAFEF00D};      lit_rd[6] = 32'h0;        lit_er[6] = 1'b0;
        ops[7] = '{1'b0, 4'b1111, 32'hFFC, 32'h0};             lit_rd[7] = 32'hCAFEF00D; lit_er[7] = 1'b0;
        ops[8] = '{1'b0, 4'b1111, 32'hFFFF_FFFC, 32'h0};       lit_rd[8] = 32'h0;        lit_er[8] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            do_txn(ops[i], 0, rd, er, lat, to, st, ok);
            model_access(1'b0, ops[i], erd, eer);
            checks++;
            if (to || rd !== lit_rd[i] || er !== lit_er[i] || lat != WAITC + 1)
                $display("FAIL errors.op%0d: rdata=%h err=%b lat=%0d to=%b, expected rdata=%h err=%b lat=%0d",
                         i, rd, er, lat, to, lit_rd[i], lit_er[i], WAITC + 1);
            else passed++;
        end
    endtask

    // Response held for 5 cycles while an intruding store is offered.
    task automatic test_backpressure();
        txn_t t;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        bit to, st, ok;
        t = '{1'b1, 4'b1111, INTRUDER_ADDR, 32'h0BADF00D};
        do_txn(t, 0, rd, er, lat, to, st, ok);
        model_access(1'b0, t, erd, eer);
        t = '{1'b0, 4'b0000, 32'h10, 32'h0};
        do_txn(t, 5, rd, er, lat, to, st, ok);
        model_access(1'b0, t, erd, eer);
        checks++;
        if (to || rd !== 32'hDEADAAEF || er !== 1'b0 || lat != WAITC + 1)
            $display("FAIL backpressure.rsp: rdata=%h err=%b lat=%0d to=%b, expected rdata=deadaaef err=0 lat=%0d",
                     rd, er, lat, to, WAITC + 1);
        else passed++;
        checks++;
        if (!st) $display("FAIL backpressure.stable: outputs or req_ready moved while held, got 0 expected 1");
        else passed++;
        checks++;
        if (!ok) $display("FAIL backpressure.release: rsp_valid/req_ready after handshake wrong, got 0 expected 1");
        else passed++;
        t = '{1'b0, 4'b0000, INTRUDER_ADDR, 32'h0};
        do_txn(t, 0, rd, er, lat, to, st, ok);
        model_access(1'b0, t, erd, eer);
        checks++;
        if (to || rd !== 32'h0BADF00D || er !== 1'b0)
            $display("FAIL backpressure.intruder: rdata=%h err=%b to=%b, expected rdata=0badf00d err=0", rd, er, to);
        else passed++;
    endtask

    // Random mix of loads/stores, byte masks, bad addresses and backpressure.
    task automatic test_random();
        txn_t t;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, hold, kind;
        bit to, st, ok;
        for (int w = 0; w < 16; w++) begin
            t = '{1'b1, 4'b1111, 32'(w * 4), $urandom};
            do_txn(t, 0, rd, er, lat, to, st, ok);
            model_access(1'b0, t, erd, eer);
            checks++;
            if (to || rd !== erd || er !== eer)
                $display("FAIL random.init%0d: rdata=%h err=%b to=%b, expected rdata=%h err=%b", w, rd, er, to, erd, eer);
            else passed++;
        end
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            t.we    = 1'($urandom);
            t.be    = 4'($urandom);
            t.wdata = $urandom;
            t.addr  = 32'($urandom_range(0, 15) * 4);
            if (kind == 8) t.addr = t.addr | 32'($urandom_range(1, 3));
            if (kind == 9) t.addr = 32'h1000 + 32'($urandom_range(0, 4000) * 4);
            hold = $urandom_range(0, 2);
            do_txn(t, hold, rd, er, lat, to, st, ok);
            model_access(1'b0, t, erd, eer);
            checks++;
            if (to || rd !== erd || er !== eer || lat != WAITC + 1 || !st || !ok)
                $display("FAIL random.op%0d: we=%b be=%b addr=%h rdata=%h err=%b lat=%0d to=%b st=%b rel=%b, expected rdata=%h err=%b lat=%0d",
                         i, t.we, t.be, t.addr, rd, er, lat, to, st, ok, erd, eer, WAITC + 1);
            else passed++;
        end
    endtask

    // WAIT_CYCLES = 0 instance with req_valid held high: 1-cycle latency, spaced acceptances.
    task automatic test_wait0_back_to_back();
        txn_t ops[$];
        logic [31:0] erd_q[$];
        logic eer_q[$];
        int acc_q[$];
        logic [31:0] erd;
        logic eer;
        int next_op = 0, got = 0, last_acc = -100, acc, lat;
        ops.push_back('{1'b1, 4'b1111, 32'h100, $urandom});
        ops.push_back('{1'b1, 4'b1111, 32'h104, $urandom});
        ops.push_back('{1'b1, 4'b1111, 32'h1FC, $urandom});
        ops.push_back('{1'b1, 4'b0101, 32'h104, $urandom});
        ops.push_back('{1'b0, 4'b0000, 32'h100, 32'h0});
        ops.push_back('{1'b0, 4'b0000, 32'h104, 32'h0});
        ops.push_back('{1'b0, 4'b0000, 32'h1FC, 32'h0});
        ops.push_back('{1'b0, 4'b0000, 32'h0FC, 32'h0});
        ops.push_back('{1'b0, 4'b0000, 32'h200, 32'h0});
        ops.push_back('{1'b0, 4'b0000, 32'h102, 32'h0});
        f_rsp_ready = 1'b1;
        for (int c = 0; c < 200 && got < ops.size(); c++) begin
            @(negedge clk);
            if (f_rsp_valid) begin
                checks++;
                if (acc_q.size() == 0) begin
                    $display("FAIL wait0.spurious: rsp_valid=1 expected 0 with nothing outstanding");
                end else begin
                    acc = acc_q.pop_front(); erd = erd_q.pop_front(); eer = eer_q.pop_front();
                    lat = cyc - acc;
                    if (f_rsp_rdata !== erd || f_rsp_err !== eer || lat != 1)
                        $display("FAIL wait0.rsp%0d: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=1",
                                 got, f_rsp_rdata, f_rsp_err, lat, erd, eer);
                    else passed++;
                end
                got++;
            end
            if (f_req_ready && next_op < ops.size()) begin
                f_req_valid = 1'b1;
                f_req_we = ops[next_op].we; f_req_be = ops[next_op].be;
                f_req_addr = ops[next_op].addr; f_req_wdata = ops[next_op].wdata;
                model_access(1'b1, ops[next_op], erd, eer);
                erd_q.push_back(erd); eer_q.push_back(eer);
                acc = cyc + 1;
                if (next_op > 0) begin
                    checks++;
                    if (acc - last_acc < 2)
                        $display("FAIL wait0.spacing%0d: spacing=%0d expected >=2", next_op, acc - last_acc);
                    else passed++;
                end
                acc_q.push_back(acc);
                last_acc = acc;
                next_op++;
            end else begin
                f_req_valid = (next_op < ops.size());
                f_req_we = 1'($urandom); f_req_be = 4'($urandom); f_req_addr = $urandom; f_req_wdata = $urandom;
            end
        end
        f_req_valid = 1'b0;
        f_rsp_ready = 1'b0;
        checks++;
        if (got != ops.size()) $display("FAIL wait0.count: responses=%0d expected %0d", got, ops.size());
        else passed++;
    endtask

    // Reset asserted during WAIT must drop a pending store.
    task automatic test_reset_mid_wait();
        txn_t t;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        bit to, st, ok;
        t = '{1'b1, 4'b1111, 32'h20, 32'h0};
        do_txn(t, 0, rd, er, lat, to, st, ok);
        model_access(1'b0, t, erd, eer);
        checks++;
        if (to || er !== 1'b0) $display("FAIL rst_wait.prestore: err=%b to=%b expected err=0 to=0", er, to);
        else passed++;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h20; req_wdata = 32'h12345678;
        for (int n = 0; n < 50 && !req_ready; n++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
            $display("FAIL rst_wait.outputs: ready=%b valid=%b rdata=%h err=%b, expected 1 0 00000000 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        t = '{1'b0, 4'b0000, 32'h20, 32'h0};
        do_txn(t, 0, rd, er, lat, to, st, ok);
        model_access(1'b0, t, erd, eer);
        checks++;
        if (to || rd !== erd || rd === 32'h12345678 || er !== 1'b0)
            $display("FAIL rst_wait.load: rdata=%h err=%b to=%b, expected rdata=%h err=0", rd, er, to, erd);
        else passed++;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_be = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        f_req_valid = 1'b0; f_req_we = 1'b0; f_req_be = '0; f_req_addr = '0; f_req_wdata = '0; f_rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_random();
        test_wait0_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
